// File: rtl/vx_dot8_arb.sv
// Round-robin arbiter that shares one LATENCY-stage dot8 PE among NUM_REQS requesters.
// Each accepted request carries {id, tag} down a tracking pipeline aligned with the PE.
module vx_dot8_arb #(
    parameter int NUM_REQS  = 4,
    parameter int TAG_WIDTH = 8,
    parameter int LATENCY   = 2,
    localparam int ID_BITS  = $clog2(NUM_REQS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQS-1:0]           req_valid,
    output logic [NUM_REQS-1:0]           req_ready,
    input  logic [NUM_REQS*32-1:0]        req_a,
    input  logic [NUM_REQS*32-1:0]        req_b,
    input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
    output logic                          pe_enable,
    output logic [31:0]                   pe_a,
    output logic [31:0]                   pe_b,
    input  logic [31:0]                   pe_result,
    output logic                          rsp_valid,
    output logic [ID_BITS-1:0]            rsp_id,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic [31:0]                   rsp_data,
    input  logic                          rsp_ready,
    output logic [31:0]                   perf_stalls
);

    logic [ID_BITS-1:0]   rr_ptr;
    logic [ID_BITS-1:0]   winner;
    logic [ID_BITS-1:0]   next_ptr;
    logic                 any_valid;
    logic                 accept;
    logic [TAG_WIDTH-1:0] win_tag;

    logic                 st_valid [LATENCY];
    logic [ID_BITS-1:0]   st_id    [LATENCY];
    logic [TAG_WIDTH-1:0] st_tag   [LATENCY];

    // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQS;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = ID_BITS'(idx);
            end
        end
    end

    // Whole pipeline advances only when the last stage is empty or draining.
    assign pe_enable = !st_valid[LATENCY-1] || rsp_ready;
    assign accept    = any_valid && pe_enable && reset_n;
    assign win_tag   = req_tag[int'(winner)*TAG_WIDTH +: TAG_WIDTH];
    assign next_ptr  = (winner == ID_BITS'(NUM_REQS-1)) ? '0 : winner + ID_BITS'(1);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        pe_a = '0;
        pe_b = '0;
        if (any_valid) begin
            pe_a = req_a[int'(winner)*32 +: 32];
            pe_b = req_b[int'(winner)*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_id[i]    <= '0;
                st_tag[i]   <= '0;
            end
        end else if (pe_enable) begin
            st_valid[0] <= accept;
            st_id[0]    <= accept ? winner  : '0;
            st_tag[0]   <= accept ? win_tag : '0;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_id[i]    <= st_id[i-1];
                st_tag[i]   <= st_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= next_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stalls <= '0;
        end else if (!pe_enable) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end

    assign rsp_valid = st_valid[LATENCY-1];
    assign rsp_id    = st_id[LATENCY-1];
    assign rsp_tag   = st_tag[LATENCY-1];
    assign rsp_data  = pe_result;

endmodule

// File: tb/tb_vx_dot8_arb.sv
// Bench for vx_dot8_arb: models a 2-stage enabled int8 dot8 PE and scores responses
// against a queue of expected {id, tag, data} filled at each observed acceptance.
module tb_vx_dot8_arb;

    localparam int NR = 4;
    localparam int TW = 8;

    typedef struct packed {
        logic [1:0]    id;
        logic [TW-1:0] tag;
        logic [31:0]   data;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_a;
    logic [NR*32-1:0]  req_b;
    logic [NR*TW-1:0]  req_tag;
    logic              pe_enable;
    logic [31:0]       pe_a;
    logic [31:0]       pe_b;
    logic [31:0]       pe_result;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [TW-1:0]     rsp_tag;
    logic [31:0]       rsp_data;
    logic              rsp_ready;
    logic [31:0]       perf_stalls;

    logic [31:0]       pe_s1;
    logic [31:0]       pe_s2;

    exp_t              sb[$];
    exp_t              mon_e;
    exp_t              mon_n;
    int                tests_run;
    int                fails;
    int                exp_ptr;

    vx_dot8_arb #(.NUM_REQS(NR), .TAG_WIDTH(TW), .LATENCY(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .pe_enable   (pe_enable),
        .pe_a        (pe_a),
        .pe_b        (pe_b),
        .pe_result   (pe_result),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_tag     (rsp_tag),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .perf_stalls (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dot8(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] s;
        logic signed [7:0]  ea;
        logic signed [7:0]  eb;
        logic signed [15:0] p;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            ea = a[i*8 +: 8];
            eb = b[i*8 +: 8];
            p  = ea * eb;
            s  = s + p;
        end
        return s;
    endfunction

    // PE model: result appears two enabled edges after its operands, held while stalled.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_s1 <= '0;
            pe_s2 <= '0;
        end else if (pe_enable) begin
            pe_s1 <= dot8(pe_a, pe_b);
            pe_s2 <= pe_s1;
        end
    end
    assign pe_result = pe_s2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_data;
        for (int i = 0; i < NR; i++) begin
            req_a[i*32 +: 32]  = $urandom;
            req_b[i*32 +: 32]  = $urandom;
            req_tag[i*TW +: TW] = TW'($urandom);
        end
    endtask

    task automatic drain;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            step;
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d responses still outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        randomize_data();
        #3;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
        end
        tests_run++;
        if (pe_enable !== 1'b1) begin
            fails++; $display("[TB] FAIL reset_pe_enable: got %b, required 1", pe_enable);
        end
        tests_run++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("[TB] FAIL reset_req_ready: got %b, required 0000", req_ready);
        end
        tests_run++;
        if (perf_stalls !== 32'd0) begin
            fails++; $display("[TB] FAIL reset_perf_stalls: got %0d, required 0", perf_stalls);
        end
        step;
        step;
        req_valid = '0;
        reset_n   = 1'b1;
        exp_ptr   = 0;
        step;
    endtask

    task automatic test_single;
        req_a[31:0]  = 32'h0102_0304;
        req_b[31:0]  = 32'h0101_0101;
        req_tag[7:0] = 8'h05;
        req_valid    = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("[TB] FAIL single_grant: got %b, required 0001", req_ready);
        end
        step;
        req_valid = '0;
        exp_ptr   = 1;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL single_early: rsp_valid %b one cycle after accept, required 0", rsp_valid);
        end
        step;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_tag !== 8'h05 || rsp_data !== 32'h0000_000A) begin
            fails++;
            $display("[TB] FAIL single_rsp: got v=%b id=%0d tag=%h data=%h, required v=1 id=0 tag=05 data=0000000a",
                     rsp_valid, rsp_id, rsp_tag, rsp_data);
        end
        step;
        drain();
    endtask

    task automatic test_all_four;
        logic [31:0] s0;
        req_valid = '1;
        rsp_ready = 1'b1;
        s0 = '0;
        for (int c = 0; c < 12; c++) begin
            randomize_data();
            @(negedge clk);
            if (c == 0) s0 = perf_stalls;
            tests_run++;
            if (req_ready !== (4'b0001 << exp_ptr)) begin
                fails++; $display("[TB] FAIL rr_grant[%0d]: got %b, required %b", c, req_ready, 4'b0001 << exp_ptr);
            end
            exp_ptr = (exp_ptr + 1) % NR;
            step;
        end
        req_valid = '0;
        tests_run++;
        if (perf_stalls !== s0) begin
            fails++; $display("[TB] FAIL full_load_stalls: got %0d, required %0d", perf_stalls, s0);
        end
        drain();
    endtask

    task automatic test_rr_skip;
        randomize_data();
        req_valid = 4'b0010;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("[TB] FAIL skip_setup: got %b, required 0010", req_ready);
        end
        step;
        req_valid = 4'b1010;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b1000) begin
            fails++; $display("[TB] FAIL skip_first: got %b, required 1000", req_ready);
        end
        step;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("[TB] FAIL skip_second: got %b, required 0010", req_ready);
        end
        step;
        req_valid = '0;
        exp_ptr   = 2;
        drain();
    endtask

    task automatic test_back_to_back;
        logic [31:0] s0;
        logic [1:0]  id0;
        logic [7:0]  tag0;
        logic [31:0] data0;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            randomize_data();
            @(negedge clk);
            tests_run++;
            if (req_ready !== (4'b0001 << exp_ptr)) begin
                fails++; $display("[TB] FAIL bp_fill[%0d]: got %b, required %b", c, req_ready, 4'b0001 << exp_ptr);
            end
            exp_ptr = (exp_ptr + 1) % NR;
            step;
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        s0 = perf_stalls; id0 = rsp_id; tag0 = rsp_tag; data0 = rsp_data;
        tests_run++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
            fails++; $display("[TB] FAIL bp_hold: req_ready=%b rsp_valid=%b, required 0000 and 1", req_ready, rsp_valid);
        end
        for (int k = 1; k < 3; k++) begin
            step;
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_tag !== tag0 || rsp_data !== data0 || req_ready !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL bp_stable[%0d]: got v=%b id=%0d tag=%h data=%h rdy=%b, required v=1 id=%0d tag=%h data=%h rdy=0000",
                         k, rsp_valid, rsp_id, rsp_tag, rsp_data, req_ready, id0, tag0, data0);
            end
        end
        step;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tests_run++;
                if (perf_stalls !== s0 + 32'd3) begin
                    fails++; $display("[TB] FAIL bp_stalls: got %0d, required %0d", perf_stalls, s0 + 32'd3);
                end
            end
            tests_run++;
            if (req_ready !== (4'b0001 << exp_ptr)) begin
                fails++; $display("[TB] FAIL bp_resume[%0d]: got %b, required %b", c, req_ready, 4'b0001 << exp_ptr);
            end
            exp_ptr = (exp_ptr + 1) % NR;
            step;
            randomize_data();
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_signed;
        req_a[64 +: 32]  = 32'h8080_8080;
        req_b[64 +: 32]  = 32'h7F7F_7F7F;
        req_tag[16 +: 8] = 8'h3C;
        req_valid        = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("[TB] FAIL signed_grant: got %b, required 0100", req_ready);
        end
        step;
        req_valid = '0;
        exp_ptr   = 3;
        step;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_tag !== 8'h3C || rsp_data !== 32'hFFFF_0200) begin
            fails++;
            $display("[TB] FAIL signed_rsp: got v=%b id=%0d tag=%h data=%h, required v=1 id=2 tag=3c data=ffff0200",
                     rsp_valid, rsp_id, rsp_tag, rsp_data);
        end
        step;
        drain();
    endtask

    task automatic test_reset_midflight;
        randomize_data();
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("[TB] FAIL mid_grant0: got %b, required 0001", req_ready);
        end
        step;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("[TB] FAIL mid_grant1: got %b, required 0010", req_ready);
        end
        step;
        req_valid = '1;
        #1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || pe_enable !== 1'b1 || req_ready !== 4'b0000 || perf_stalls !== 32'd0) begin
            fails++;
            $display("[TB] FAIL mid_async: got v=%b en=%b rdy=%b stalls=%0d, required v=0 en=1 rdy=0000 stalls=0",
                     rsp_valid, pe_enable, req_ready, perf_stalls);
        end
        sb.delete();
        rsp_ready = 1'b1;
        step;
        step;
        req_valid = '0;
        reset_n   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL mid_ghost[%0d]: rsp_valid %b after release, required 0", c, rsp_valid);
            end
            step;
        end
        req_valid = '1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("[TB] FAIL mid_ptr: got %b, required 0001", req_ready);
        end
        step;
        req_valid = '0;
        exp_ptr   = 1;
        drain();
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        exp_ptr   = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        // Scoreboard: pop on every response transfer, push on every observed acceptance.
        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    if (rsp_valid && rsp_ready) begin
                        tests_run++;
                        if (sb.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL sb_unexpected: got id=%0d tag=%h data=%h, required no response",
                                     rsp_id, rsp_tag, rsp_data);
                        end else begin
                            mon_e = sb.pop_front();
                            if (rsp_id !== mon_e.id || rsp_tag !== mon_e.tag || rsp_data !== mon_e.data) begin
                                fails++;
                                $display("[TB] FAIL sb_rsp: got id=%0d tag=%h data=%h, required id=%0d tag=%h data=%h",
                                         rsp_id, rsp_tag, rsp_data, mon_e.id, mon_e.tag, mon_e.data);
                            end
                        end
                    end
                    for (int i = 0; i < NR; i++) begin
                        if (req_valid[i] && req_ready[i]) begin
                            mon_n.id   = 2'(i);
                            mon_n.tag  = req_tag[i*TW +: TW];
                            mon_n.data = dot8(req_a[i*32 +: 32], req_b[i*32 +: 32]);
                            sb.push_back(mon_n);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_all_four();
        test_rr_skip();
        test_back_to_back();
        test_signed();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vx_dot8_arb.md
VX_DOT8_ARB -- requirements
Module: VX_dot8_arb

Interface
Parameters:
REQ-001: NUM_REQS, 4, number of requesters sharing one dot8 PE; legal range 2 to 16.
REQ-002: TAG_WIDTH, 8, width of the opaque per-request tag returned with the result; minimum 1.
REQ-003: LATENCY, 2, enabled-cycle latency of the attached dot8 PE; minimum 1.
REQ-004: ID_BITS, derived as CLOG2(NUM_REQS), width of the requester index.

Ports:
REQ-005: clk  in  1  single clock; all state updates on the rising edge.
REQ-006: reset_n  in  1  reset, asynchronous and active-low.
REQ-007: req_valid  in  NUM_REQS  per-requester request valid.
REQ-008: req_ready  out  NUM_REQS  per-requester accept; at most one bit high per cycle.
REQ-009: req_a  in  NUM_REQS x 32  packed 4x int8 operand A.
REQ-010: req_b  in  NUM_REQS x 32  packed 4x int8 operand B.
REQ-011: req_tag  in  NUM_REQS x TAG_WIDTH  opaque per-request tag.
REQ-012: pe_enable  out  1  PE pipeline advance enable.
REQ-013: pe_a  out  32  operand A of the granted request.
REQ-014: pe_b  out  32  operand B of the granted request.
REQ-015: pe_result  in  32  PE output; valid LATENCY enabled edges after its operands were presented with pe_enable high, and held while pe_enable is low.
REQ-016: rsp_valid  out  1  response valid.
REQ-017: rsp_id  out  ID_BITS  index of the originating requester.
REQ-018: rsp_tag  out  TAG_WIDTH  tag of the originating request.
REQ-019: rsp_data  out  32  dot-product result, equal to pe_result.
REQ-020: rsp_ready  in  1  response accept.
REQ-021: perf_stalls  out  32  count of cycles with pe_enable low.

Function
REQ-022: The tracking pipeline SHALL be LATENCY stages deep; each stage holds {valid, id, tag} and all stages advance together only when pe_enable is 1.
REQ-023: rsp_valid, rsp_id and rsp_tag SHALL come directly from the last tracking stage, and rsp_data SHALL equal pe_result.
REQ-024: pe_enable SHALL be computed as (NOT last-stage valid) OR rsp_ready.
REQ-025: A response transfer SHALL occur on any cycle where rsp_valid and rsp_ready are both 1.
REQ-026: While rsp_valid is 1 and rsp_ready is 0, rsp_valid, rsp_id, rsp_tag and rsp_data SHALL remain stable.
REQ-027: Arbitration SHALL be round-robin from pointer rr_ptr.
  - The winner is the first i with req_valid[i]=1 in the order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQS.
REQ-028: req_ready[winner] SHALL equal pe_enable, and every other req_ready bit SHALL be 0.
  - req_ready SHALL NOT depend on req_ready.
REQ-029: On each accepted request (req_valid AND req_ready), the block SHALL:
  - load stage 0 with {1, winner, req_tag[winner]};
  - set rr_ptr to (winner+1) mod NUM_REQS, wrapping from NUM_REQS-1 to 0.
REQ-030: On an enabled cycle with no req_valid, stage 0 SHALL load valid=0 (a bubble), and rr_ptr SHALL be unchanged.
REQ-031: pe_a and pe_b SHALL present the winner's operands, and SHALL be 0 when no request is valid.
REQ-032: With no stall, the latency SHALL be exactly LATENCY cycles from the acceptance edge to rsp_valid.
  - Throughput SHALL be one request per cycle.
REQ-033: When the pipeline is full and a response transfers, a new request SHALL be accepted in the same cycle; there are no bubbles under full load.
REQ-034: perf_stalls SHALL increment by 1 on every cycle in which pe_enable is 0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-035: Responses SHALL leave in acceptance order, and no request SHALL be dropped or duplicated.

Reset
REQ-036: While reset_n is 0, the block SHALL hold:
  - all stage valids at 0, all ids at 0, all tags at 0;
  - rr_ptr at 0;
  - perf_stalls at 0.
  This is asynchronous: outputs respond immediately, with no clock edge required.
REQ-037: During reset, rsp_valid SHALL be 0, and pe_enable SHALL be 1 as a consequence of REQ-024.
  - req_ready is forced to 0 while reset_n is 0.
REQ-038: In-flight requests at reset SHALL be discarded, and no response for them SHALL appear after reset_n is released.

Verification
Bench setup: NUM_REQS=4, LATENCY=2, PE model = 2-stage enabled signed int8 dot product.
REQ-039: Single request.
  - Stimulus: req 0 only, a=0x01020304, b=0x01010101, tag=0x05, rsp_ready=1.
  - Response: rsp_valid 2 cycles later, rsp_id=0, tag=0x05, data=0x0000000A.
REQ-040: All four requesters valid continuously, rsp_ready=1.
  - Response: grants 0,1,2,3,0,1,...; rsp_id follows the same sequence delayed 2 cycles; perf_stalls=0.
REQ-041: Round-robin skip.
  - Stimulus: rr_ptr=2, req_valid=4'b1010.
  - Response: req 3 is granted first, then req 1 on the next cycle.
REQ-042: Back-pressure.
  - Stimulus: pipeline full, rsp_ready=0 for 3 cycles.
  - Response: rsp outputs stable, req_ready=0, perf_stalls increases by 3, all responses delivered afterwards in order.
REQ-043: Signed operands.
  - Stimulus: a=0x80808080, b=0x7F7F7F7F.
  - Response: data=0xFFFF0200 (that is, -65024).
REQ-044: Reset mid-flight.
  - Stimulus: reset_n drops with 2 requests in flight.
  - Response: rsp_valid=0 immediately, rr_ptr=0, and no response appears after release.
